// File: rtl/conv_layer_pixel_cache_output_if.sv
// Block-in / word-out bus of the convolution output cache: parallel result
// handshake from the kernel array plus the single-port result RAM write port.
interface conv_layer_pixel_cache_output_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PORT_NUM   = 6,
    parameter int ADDR_WIDTH = 6
);
    logic                           in_valid;
    logic [DATA_WIDTH*PORT_NUM-1:0] in_result_port;
    logic                           in_ready;
    logic [ADDR_WIDTH-1:0]          ram_addr;
    logic [DATA_WIDTH-1:0]          ram_data;
    logic                           ram_we;

    modport master (
        output in_valid,
        output in_result_port,
        input  in_ready,
        input  ram_addr,
        input  ram_data,
        input  ram_we
    );

    modport slave (
        input  in_valid,
        input  in_result_port,
        output in_ready,
        output ram_addr,
        output ram_data,
        output ram_we
    );
endinterface

// File: rtl/conv_layer_pixel_cache_output.sv
// Buffers one parallel block of kernel results and serializes it into the result RAM.
// Optional macro CONV_OUT_RELU_EN clamps negative (sign-bit set) words to zero on write.
module conv_layer_pixel_cache_output #(
    parameter int DATA_WIDTH  = 32,
    parameter int PORT_NUM    = 6,
    parameter int ADDR_WIDTH  = 6,
    parameter int FRAME_WORDS = 36
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    conv_layer_pixel_cache_output_if.slave       bus,
    output logic [2:0]                           current_state,
    output logic                                 done
);
    localparam int WIDX_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        WRITE   = 3'd2,
        DONE    = 3'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [ADDR_WIDTH-1:0]  wptr_r;
    logic [ADDR_WIDTH-1:0]  wptr_nxt_s;
    logic [WIDX_W-1:0]      widx_r;
    logic [WIDX_W-1:0]      widx_nxt_s;
    logic                   capture_s;
    logic                   last_word_s;
    logic                   frame_end_s;
    logic [DATA_WIDTH-1:0]  buf_r [PORT_NUM];
    logic [DATA_WIDTH-1:0]  data_nxt_s;
    logic [ADDR_WIDTH-1:0]  addr_nxt_s;
    logic                   in_ready_r;
    logic                   ram_we_r;
    logic                   done_r;
    logic [ADDR_WIDTH-1:0]  ram_addr_r;
    logic [DATA_WIDTH-1:0]  ram_data_r;

    // Word as it goes onto the RAM data bus; the clamp sits here so latency is unaffected.
    function automatic logic [DATA_WIDTH-1:0] relu_word(input logic [DATA_WIDTH-1:0] w);
`ifdef CONV_OUT_RELU_EN
        if (w[DATA_WIDTH-1]) begin
            relu_word = {DATA_WIDTH{1'b0}};
        end else begin
            relu_word = w;
        end
`else
        relu_word = w;
`endif
    endfunction

    assign last_word_s = (widx_r == WIDX_W'(PORT_NUM - 1));
    assign frame_end_s = ((32'(wptr_r) + 32'd1) == 32'(FRAME_WORDS));

    // Next-state, pointer and next-output decode; outputs are registered from these.
    always_comb begin
        state_nxt_s = state_r;
        wptr_nxt_s  = wptr_r;
        widx_nxt_s  = widx_r;
        capture_s   = 1'b0;
        data_nxt_s  = ram_data_r;
        addr_nxt_s  = ram_addr_r;
        case (state_r)
            IDLE: begin
                wptr_nxt_s = {ADDR_WIDTH{1'b0}};
                if (enable) begin
                    state_nxt_s = CAPTURE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CAPTURE: begin
                // enable wins over in_valid: a falling enable aborts the frame
                if (!enable) begin
                    state_nxt_s = IDLE;
                    wptr_nxt_s  = {ADDR_WIDTH{1'b0}};
                end else if (bus.in_valid) begin
                    state_nxt_s = WRITE;
                    capture_s   = 1'b1;
                    widx_nxt_s  = {WIDX_W{1'b0}};
                    addr_nxt_s  = wptr_r;
                    data_nxt_s  = relu_word(bus.in_result_port[DATA_WIDTH*PORT_NUM-1 -: DATA_WIDTH]);
                end else begin
                    state_nxt_s = CAPTURE;
                end
            end
            WRITE: begin
                wptr_nxt_s = wptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                widx_nxt_s = widx_r + {{(WIDX_W-1){1'b0}}, 1'b1};
                if (last_word_s) begin
                    widx_nxt_s = {WIDX_W{1'b0}};
                    if (frame_end_s) begin
                        state_nxt_s = DONE;
                        wptr_nxt_s  = {ADDR_WIDTH{1'b0}};
                    end else begin
                        state_nxt_s = CAPTURE;
                    end
                end else begin
                    state_nxt_s = WRITE;
                    addr_nxt_s  = wptr_nxt_s;
                    data_nxt_s  = relu_word(buf_r[widx_nxt_s]);
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
                wptr_nxt_s  = {ADDR_WIDTH{1'b0}};
            end
            default: begin
                state_nxt_s = IDLE;
                wptr_nxt_s  = {ADDR_WIDTH{1'b0}};
                widx_nxt_s  = {WIDX_W{1'b0}};
            end
        endcase
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            wptr_r     <= {ADDR_WIDTH{1'b0}};
            widx_r     <= {WIDX_W{1'b0}};
            in_ready_r <= 1'b0;
            ram_we_r   <= 1'b0;
            done_r     <= 1'b0;
            ram_addr_r <= {ADDR_WIDTH{1'b0}};
            ram_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            wptr_r     <= wptr_nxt_s;
            widx_r     <= widx_nxt_s;
            in_ready_r <= (state_nxt_s == CAPTURE);
            ram_we_r   <= (state_nxt_s == WRITE);
            done_r     <= (state_nxt_s == DONE);
            ram_addr_r <= addr_nxt_s;
            ram_data_r <= data_nxt_s;
        end
    end

    // Single-block holding buffer; word 0 comes from the MSBs of the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                buf_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (capture_s) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                buf_r[i] <= bus.in_result_port[DATA_WIDTH*(PORT_NUM-i)-1 -: DATA_WIDTH];
            end
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.ram_we     = ram_we_r;
    assign bus.ram_addr   = ram_addr_r;
    assign bus.ram_data   = ram_data_r;
    assign done           = done_r;
    assign current_state  = state_r;
endmodule

// File: tb/tb_conv_layer_pixel_cache_output.sv
// Directed bench for conv_layer_pixel_cache_output: reset, block serialization,
// full frame with done, abort, mid-write enable drop and reset, negative words.
module tb_conv_layer_pixel_cache_output;
    logic       clk;
    logic       rst;
    logic       enable;
    logic [2:0] current_state;
    logic       done;
    int         n_assert;
    int         n_fail;

    conv_layer_pixel_cache_output_if #(.DATA_WIDTH(32), .PORT_NUM(6), .ADDR_WIDTH(6)) bus ();

    conv_layer_pixel_cache_output #(
        .DATA_WIDTH(32), .PORT_NUM(6), .ADDR_WIDTH(6), .FRAME_WORDS(36)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .bus           (bus),
        .current_state (current_state),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [191:0] blk, input int k);
        logic [31:0] w;
        w = blk[191 - 32*k -: 32];
`ifdef CONV_OUT_RELU_EN
        if (w[31]) w = 32'h0000_0000;
`endif
        return w;
    endfunction

    function automatic logic [191:0] mk_blk(input int s);
        logic [191:0] b;
        for (int i = 0; i < 6; i++) begin
            b[191 - 32*i -: 32] = 32'h4000_0000 | (32'(s + i) << 8);
        end
        return b;
    endfunction

    // Handshake one block from CAPTURE and check its six writes; optionally drop enable.
    task automatic send_block(input logic [191:0] blk, input int base, input int drop_after);
        chk("hs_ready", 32'(bus.in_ready), 32'd1);
        bus.in_result_port = blk;
        bus.in_valid       = 1'b1;
        step();
        bus.in_valid       = 1'b0;
        bus.in_result_port = ~blk;
        for (int k = 0; k < 6; k++) begin
            chk("wr_we",    32'(bus.ram_we),   32'd1);
            chk("wr_addr",  32'(bus.ram_addr), 32'(base + k));
            chk("wr_data",  bus.ram_data,      exp_word(blk, k));
            chk("wr_ready", 32'(bus.in_ready), 32'd0);
            chk("wr_done",  32'(done),         32'd0);
            if (k == drop_after) enable = 1'b0;
            step();
        end
    endtask

    initial begin
        logic [191:0] blk0;
        logic [191:0] relu_blk;
        n_assert = 0;
        n_fail   = 0;
        blk0     = {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                    32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};
        relu_blk = {32'hBF80_0000, 32'h8000_0000, 32'h3F80_0000,
                    32'h0000_0000, 32'hC000_0000, 32'h7F7F_FFFF};

        rst = 1'b1;
        enable = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_result_port = '0;
        step();
        step();
        chk("rst_state", 32'(current_state), 32'd0);
        chk("rst_ready", 32'(bus.in_ready),  32'd0);
        chk("rst_we",    32'(bus.ram_we),    32'd0);
        chk("rst_addr",  32'(bus.ram_addr),  32'd0);
        chk("rst_data",  bus.ram_data,       32'd0);
        chk("rst_done",  32'(done),          32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_state", 32'(current_state), 32'd1);
        chk("post_rst_ready", 32'(bus.in_ready),  32'd1);

        // First block of the frame, then last values hold while ram_we is low
        send_block(blk0, 0, -1);
        chk("hold_we",   32'(bus.ram_we),   32'd0);
        chk("hold_addr", 32'(bus.ram_addr), 32'd5);
        chk("hold_data", bus.ram_data,      32'h40C0_0000);

        for (int b = 1; b < 6; b++) begin
            send_block(mk_blk(6 * b), 6 * b, -1);
        end
        chk("done_pulse", 32'(done),          32'd1);
        chk("done_we",    32'(bus.ram_we),    32'd0);
        chk("done_state", 32'(current_state), 32'd3);
        chk("done_ready", 32'(bus.in_ready),  32'd0);
        step();
        chk("done_clear", 32'(done),          32'd0);
        chk("idle_state", 32'(current_state), 32'd0);
        chk("idle_ready", 32'(bus.in_ready),  32'd0);
        step();
        chk("rearm_ready", 32'(bus.in_ready),  32'd1);
        send_block(mk_blk(100), 0, -1);

        // Abort after two blocks of a frame
        send_block(mk_blk(200), 6, -1);
        enable = 1'b0;
        step();
        chk("abort_state", 32'(current_state), 32'd0);
        chk("abort_ready", 32'(bus.in_ready),  32'd0);
        chk("abort_done",  32'(done),          32'd0);
        step();
        chk("abort_done2", 32'(done),          32'd0);
        chk("abort_we",    32'(bus.ram_we),    32'd0);
        enable = 1'b1;
        step();
        chk("reen_state", 32'(current_state), 32'd1);
        send_block(mk_blk(300), 0, -1);

        // enable falls after the third write; the block still completes
        send_block(mk_blk(400), 6, 2);
        chk("drop_cap_state", 32'(current_state), 32'd1);
        step();
        chk("drop_idle_state", 32'(current_state), 32'd0);
        chk("drop_done",       32'(done),          32'd0);
        chk("drop_we",         32'(bus.ram_we),    32'd0);
        enable = 1'b1;
        step();
        chk("drop_reen_state", 32'(current_state), 32'd1);

        // rst pulse after the third write
        bus.in_result_port = mk_blk(500);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rstw_we",   32'(bus.ram_we),   32'd1);
            chk("rstw_addr", 32'(bus.ram_addr), 32'(k));
            if (k == 2) rst = 1'b1;
            step();
        end
        chk("rstw_we_off", 32'(bus.ram_we),    32'd0);
        chk("rstw_state",  32'(current_state), 32'd0);
        chk("rstw_data",   bus.ram_data,       32'd0);
        rst = 1'b0;
        step();
        chk("rstw_state2", 32'(current_state), 32'd1);
        chk("rstw_we2",    32'(bus.ram_we),    32'd0);
        step();
        chk("rstw_we3",    32'(bus.ram_we),    32'd0);

        // Negative words, including -0.0
        send_block(relu_blk, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
